// File: rtl/regfile_multiport.sv
// Multi-port integer register file with write-through bypass, a clear sequencer
// after reset, and a per-register busy scoreboard for multi-cycle producers.
module regfile_multiport #(
   parameter  int DATA_WIDTH    = 32,
   parameter  int NUM_REGISTERS = 32,
   parameter  int NUM_READ      = 2,
   parameter  int NUM_WRITE     = 2,
   parameter  int ZERO_REG      = 1,
   localparam int AW            = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   output logic                           ready,
   input  logic [NUM_WRITE-1:0]           wr_en,
   input  logic [NUM_WRITE*AW-1:0]        wr_addr,
   input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data,
   input  logic [NUM_READ*AW-1:0]         rd_addr,
   output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
   output logic [NUM_READ-1:0]            rd_busy,
   input  logic                           rsv_en,
   input  logic [AW-1:0]                  rsv_addr
);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t                  state_q, state_d;
   logic [AW-1:0]           clr_cnt_q, clr_cnt_d;
   logic [DATA_WIDTH-1:0]   regs_q [NUM_REGISTERS];
   logic [NUM_REGISTERS-1:0] busy_q, busy_d;

   logic [AW-1:0]           ra;
   logic                    hit;
   logic [DATA_WIDTH-1:0]   val;

   // True for addresses that hold real, writable state.
   function automatic logic live(input logic [AW-1:0] a);
      return (int'(a) < NUM_REGISTERS) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   assign ready = (state_q == RUN);

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == CLEAR) begin
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (clr_cnt_q == AW'(NUM_REGISTERS - 1)) begin
            state_d   = RUN;
            clr_cnt_d = '0;
         end
      end
   end

   // Releases are applied before the reserve so a new producer supersedes the old one.
   always_comb begin
      busy_d = busy_q;
      if (state_q == RUN) begin
         for (int unsigned w = 0; w < NUM_WRITE; w++) begin
            if (wr_en[w] && live(wr_addr[w*AW +: AW]))
               busy_d[wr_addr[w*AW +: AW]] = 1'b0;
         end
         if (rsv_en && live(rsv_addr))
            busy_d[rsv_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
         busy_q    <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         busy_q    <= busy_d;
      end
   end

   // Later ports overwrite earlier ones, giving the highest index priority.
   always_ff @(posedge clk) begin
      if (state_q == CLEAR) begin
         regs_q[clr_cnt_q] <= '0;
      end else if (!rst) begin
         for (int unsigned w = 0; w < NUM_WRITE; w++) begin
            if (wr_en[w] && live(wr_addr[w*AW +: AW]))
               regs_q[wr_addr[w*AW +: AW]] <= wr_data[w*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      ra      = '0;
      hit     = 1'b0;
      val     = '0;
      for (int unsigned r = 0; r < NUM_READ; r++) begin
         ra  = rd_addr[r*AW +: AW];
         hit = 1'b0;
         val = '0;
         if (ready && live(ra)) begin
            val = regs_q[ra];
            for (int unsigned w = 0; w < NUM_WRITE; w++) begin
               if (wr_en[w] && (wr_addr[w*AW +: AW] == ra)) begin
                  val = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
                  hit = 1'b1;
               end
            end
            rd_data[r*DATA_WIDTH +: DATA_WIDTH] = val;
            rd_busy[r]                          = busy_q[ra] & ~hit;
         end
      end
   end

endmodule

// File: tb/tb_regfile_multiport.sv
// Randomized and directed bench for regfile_multiport against an array-based
// reference model; a second 24-entry instance covers out-of-range addressing.
module tb_regfile_multiport;

   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int DW   = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          ready;
   logic [1:0]    wr_en;
   logic [9:0]    wr_addr;
   logic [63:0]   wr_data;
   logic [9:0]    rd_addr;
   logic [63:0]   rd_data;
   logic [1:0]    rd_busy;
   logic          rsv_en;
   logic [4:0]    rsv_addr;

   logic          s_rst;
   logic          s_ready;
   logic [0:0]    s_wr_en;
   logic [4:0]    s_wr_addr;
   logic [31:0]   s_wr_data;
   logic [14:0]   s_rd_addr;
   logic [95:0]   s_rd_data;
   logic [2:0]    s_rd_busy;
   logic          s_rsv_en;
   logic [4:0]    s_rsv_addr;

   int            n_checks = 0;
   int            n_pass   = 0;

   logic [31:0]   m_mem [NREG];
   bit            m_busy [NREG];
   bit            m_ready;
   int            m_clr_left;

   always #5 clk = ~clk;

   regfile_multiport #(
      .DATA_WIDTH(32), .NUM_REGISTERS(32), .NUM_READ(2), .NUM_WRITE(2), .ZERO_REG(1)
   ) dut (
      .clk(clk), .rst(rst), .ready(ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr)
   );

   regfile_multiport #(
      .DATA_WIDTH(32), .NUM_REGISTERS(24), .NUM_READ(3), .NUM_WRITE(1), .ZERO_REG(1)
   ) dut24 (
      .clk(clk), .rst(s_rst), .ready(s_ready),
      .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
      .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_busy(s_rd_busy),
      .rsv_en(s_rsv_en), .rsv_addr(s_rsv_addr)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic logic [31:0] exp_rd(input int p);
      int a = int'(rd_addr[p*AW +: AW]);
      logic [31:0] v;
      if (!m_ready || a >= NREG || a == 0) return '0;
      v = m_mem[a];
      for (int w = 0; w < 2; w++)
         if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) v = wr_data[w*DW +: DW];
      return v;
   endfunction

   function automatic logic exp_busy(input int p);
      int a = int'(rd_addr[p*AW +: AW]);
      if (!m_ready || a >= NREG || a == 0) return 1'b0;
      for (int w = 0; w < 2; w++)
         if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic model_step();
      if (rst) begin
         m_ready    = 1'b0;
         m_clr_left = NREG;
         for (int i = 0; i < NREG; i++) begin m_busy[i] = 1'b0; m_mem[i] = '0; end
      end else if (!m_ready) begin
         m_clr_left--;
         if (m_clr_left == 0) m_ready = 1'b1;
      end else begin
         for (int w = 0; w < 2; w++) begin
            int a = int'(wr_addr[w*AW +: AW]);
            if (wr_en[w] && a != 0 && a < NREG) begin
               m_mem[a]  = wr_data[w*DW +: DW];
               m_busy[a] = 1'b0;
            end
         end
         if (rsv_en && rsv_addr != 0 && int'(rsv_addr) < NREG) m_busy[rsv_addr] = 1'b1;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      chk("ready", 32'(ready), 32'(m_ready));
      for (int p = 0; p < 2; p++) begin
         chk("rd_data", rd_data[p*DW +: DW], exp_rd(p));
         chk("rd_busy", 32'(rd_busy[p]), 32'(exp_busy(p)));
      end
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
      rd_addr = '0; rsv_en = 1'b0; rsv_addr = '0;
   endtask

   function automatic logic [4:0] rand_addr();
      return ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
   endfunction

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!ready && n < 100) begin tick(); n++; end
      chk(tag, 32'(n), 32'(NREG));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      rst = 1'b1;
      s_rst = 1'b1; s_wr_en = '0; s_wr_addr = '0; s_wr_data = '0;
      s_rd_addr = '0; s_rsv_en = 1'b0; s_rsv_addr = '0;
      model_step();
      @(posedge clk); #1;

      // Reset state, then clear length and zeroed contents.
      tick();
      rst = 1'b0;
      wait_ready("clr_len");
      for (int r = 0; r < NREG; r++) begin
         rd_addr = {5'(r + 1), 5'(r)};
         #1 chk("clr_zero", rd_data[31:0], 32'h0);
         tick();
      end

      // Mid-clear reset with writes to x5 that must be ignored.
      idle(); rst = 1'b1; tick();
      rst = 1'b0; wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[31:0] = 32'hAA;
      repeat (10) tick();
      rst = 1'b1; tick();
      rst = 1'b0;
      wait_ready("midclr_len");
      wr_en = '0; rd_addr = {5'd0, 5'd5};
      #1 chk("x5_ignored", rd_data[31:0], 32'h0);
      tick();

      // Write conflict and x0 write.
      idle();
      wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11}; rd_addr = {5'd0, 5'd7};
      #1 chk("conflict_byp", rd_data[31:0], 32'h22);
      tick();
      wr_en = '0;
      #1 chk("conflict_st", rd_data[31:0], 32'h22);
      tick();
      wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hFF}; rd_addr = '0;
      tick();
      wr_en = '0;
      #1 chk("x0_zero", rd_data[31:0], 32'h0);
      tick();

      // Bypass on both read ports.
      idle(); wr_en = 2'b01; wr_addr[4:0] = 5'd3; wr_data[31:0] = 32'h5; tick();
      wr_data[31:0] = 32'h9; rd_addr = {5'd3, 5'd3};
      #1 chk("byp_p0", rd_data[31:0], 32'h9);
      chk("byp_p1", rd_data[63:32], 32'h9);
      tick();

      // Scoreboard.
      idle(); rsv_en = 1'b1; rsv_addr = 5'd4; rd_addr = {5'd0, 5'd4};
      #1 chk("rsv_same_cyc", 32'(rd_busy[0]), 32'h0);
      tick();
      rsv_en = 1'b0;
      #1 chk("busy_set", 32'(rd_busy[0]), 32'h1);
      wr_en = 2'b10; wr_addr = {5'd4, 5'd0}; wr_data = {32'h1, 32'h0};
      #1 chk("busy_release", 32'(rd_busy[0]), 32'h0);
      chk("release_data", rd_data[31:0], 32'h1);
      tick();
      rsv_en = 1'b1; rsv_addr = 5'd4; wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h2};
      tick();
      idle(); rd_addr = {5'd0, 5'd4};
      #1 chk("rsv_wins", 32'(rd_busy[0]), 32'h1);
      chk("rsv_wins_data", rd_data[31:0], 32'h2);
      tick();

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 2000; i++) begin
         rst   = ($urandom_range(0, 299) == 0);
         wr_en = 2'($urandom);
         for (int w = 0; w < 2; w++) begin
            wr_addr[w*AW +: AW] = rand_addr();
            wr_data[w*DW +: DW] = $urandom;
            rd_addr[w*AW +: AW] = rand_addr();
         end
         rsv_en   = ($urandom_range(0, 3) == 0);
         rsv_addr = rand_addr();
         tick();
      end
      idle();

      // 24-entry, 3-read, 1-write instance.
      chk("s_rst_ready", 32'(s_ready), 32'h0);
      chk("s_rst_rd", s_rd_data[31:0], 32'h0);
      s_rst = 1'b0;
      begin
         int n = 0;
         while (!s_ready && n < 100) begin @(posedge clk); #1; n++; end
         chk("s_clr_len", 32'(n), 32'd24);
      end
      s_wr_en = 1'b1; s_wr_addr = 5'd30; s_wr_data = 32'hDEAD;
      s_rsv_en = 1'b1; s_rsv_addr = 5'd30; s_rd_addr = {5'd6, 5'd5, 5'd30};
      #1 chk("s_oor_rd", s_rd_data[31:0], 32'h0);
      chk("s_oor_busy", 32'(s_rd_busy[0]), 32'h0);
      @(posedge clk); #1;
      s_wr_en = 1'b0; s_rsv_en = 1'b0;
      #1 chk("s_oor_rd2", s_rd_data[31:0], 32'h0);
      chk("s_oor_busy2", 32'(s_rd_busy[0]), 32'h0);
      chk("s_x5", s_rd_data[63:32], 32'h0);
      chk("s_x6", s_rd_data[95:64], 32'h0);
      s_wr_en = 1'b1; s_wr_addr = 5'd23; s_wr_data = 32'hCAFE;
      s_rsv_en = 1'b1; s_rsv_addr = 5'd23; s_rd_addr = {5'd5, 5'd5, 5'd23};
      @(posedge clk); #1;
      s_rsv_en = 1'b0; s_wr_addr = 5'd5; s_wr_data = 32'h1234;
      #1 chk("s_x23", s_rd_data[31:0], 32'hCAFE);
      chk("s_x23_busy", 32'(s_rd_busy[0]), 32'h1);
      chk("s_x5_byp", s_rd_data[63:32], 32'h1234);
      @(posedge clk); #1;
      s_wr_en = 1'b0;
      #1 chk("s_x5_st", s_rd_data[95:64], 32'h1234);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the single-write, dual-read integer register file.
- Configurable read-port and write-port counts, with per-port write-through bypass and fixed write-port priority.
- Hardware clear sequencer after reset, plus a per-register busy scoreboard for multi-cycle producers.
- Sits in decode: read ports feed operand fetch, write ports are fed by the writeback lanes.

Parameters:
- DATA_WIDTH, 32, bits per register.
- NUM_REGISTERS, 32, register count; need not be a power of two. AW = $clog2(NUM_REGISTERS).
- NUM_READ, 2, read port count (1..8).
- NUM_WRITE, 2, write port count (1..4).
- ZERO_REG, 1, when 1 register 0 is hardwired to zero.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- ready  out  1  high when clearing is done and the file is usable.
- wr_en  in  NUM_WRITE  per-port write enable.
- wr_addr  in  NUM_WRITE*AW  packed write addresses; port p is bits [p*AW +: AW].
- wr_data  in  NUM_WRITE*DATA_WIDTH  packed write data.
- rd_addr  in  NUM_READ*AW  packed read addresses.
- rd_data  out  NUM_READ*DATA_WIDTH  packed read data, combinational.
- rd_busy  out  NUM_READ  addressed register has a pending producer.
- rsv_en  in  1  reserve (mark busy) the register at rsv_addr.
- rsv_addr  in  AW  register to reserve.

Behaviour:
- FSM states CLEAR and RUN.
  - rst=1 (any state, including mid-clear) at an edge: state=CLEAR, clr_cnt=0, all busy bits=0, ready=0.
  - CLEAR: each cycle write 0 to registers[clr_cnt] and increment clr_cnt.
  - When clr_cnt==NUM_REGISTERS-1 the transition to RUN is registered, so ready=1 exactly NUM_REGISTERS cycles after rst deasserts.
  - RUN persists until the next rst.
- While ready=0:
  - wr_en and rsv_en are ignored.
  - rd_data=0 and rd_busy=0 on all ports.
- Writes (RUN only):
  - Each enabled port writes at the edge.
  - Same address on several ports: the highest port index wins.
  - Writes are dropped to address 0 when ZERO_REG=1, and to any address >= NUM_REGISTERS.
- Reads, evaluated per read port, first matching rule wins:
  1. Address >= NUM_REGISTERS -> 0.
  2. Address 0 and ZERO_REG=1 -> 0.
  3. Any enabled write port matches -> that port's wr_data, using the highest index among matching ports (same-cycle bypass).
  4. Otherwise -> stored value.
- Scoreboard (RUN only):
  - busy[r] is set at the edge when rsv_en=1 and rsv_addr=r.
  - busy[r] is cleared at the edge when any enabled write port targets r.
  - Reserve and write to the same r in the same cycle: reserve wins, busy stays 1 (a new producer supersedes the old one).
  - Reserve of address 0 (ZERO_REG=1) or an out-of-range address is ignored.
- rd_busy[p] = busy[rd_addr[p]] AND NOT (any enabled write port targets rd_addr[p]).
  - A same-cycle release is visible; a same-cycle reserve is not.
  - rd_busy[p]=0 for address 0 (ZERO_REG=1) and for out-of-range addresses.
- Latency: reads and busy are zero-cycle combinational; writes are visible in storage the cycle after the edge.
- Reset values: ready=0, rd_data=0, rd_busy=0, storage zeroed by the end of CLEAR.

Test Plan:
- Clear: assert rst for 1 cycle, release -> ready=0 for exactly 32 cycles, then 1; all 32 registers read 0.
- Mid-clear reset: release rst, wait 10 cycles, assert rst for 1 cycle -> ready rises 32 cycles after the second release. A wr_en to x5 with 0xAA during CLEAR is ignored, so x5 reads 0 in RUN.
- Write conflict: ports 0 and 1 both write x7 (0x11, 0x22) -> same-cycle rd_addr=7 returns 0x22, next cycle stores 0x22. A write of 0xFF to x0 -> x0 reads 0.
- Bypass: x3=0x5 stored; write 0x9 to x3 while reading x3 on both read ports -> both return 0x9 that cycle.
- Scoreboard: reserve x4 -> next cycle rd_busy=1 for x4. Write x4=0x1 -> rd_busy=0 in that same cycle and the data is bypassed. Reserve x4 and write x4 in the same cycle -> busy stays 1.
- Config NUM_REGISTERS=24, NUM_READ=3, NUM_WRITE=1 -> CLEAR lasts 24 cycles. Address 30: read gives 0, write is dropped, reserve is ignored, rd_busy=0.
